// File: rtl/seq_checker.sv
// Receive-side checker for the n(x) = n(x-2) + n(x-3) sequence stream.
// Self-seeds from the first three samples, then flags each sample as match or error.
module seq_checker #(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] seq_i,
  input  logic              valid_i,
  input  logic              clear_i,
  output logic              match_o,
  output logic              error_o,
  output logic              locked_o,
  output logic [CNT_W-1:0]  match_count_o,
  output logic [CNT_W-1:0]  err_count_o
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);

  typedef enum logic [1:0] {FILL, CHECK, LOCK} state_t;

  state_t            state_p1, state_d;
  logic [1:0]        fill_p1, fill_d;
  logic [RUN_W-1:0]  run_p1, run_d;
  logic [DATA_W-1:0] h1_p1, h2_p1, h3_p1, h1_d, h2_d, h3_d;
  logic              match_p1, match_d, error_p1, error_d;
  logic [CNT_W-1:0]  mcnt_p1, mcnt_d, ecnt_p1, ecnt_d;
  logic [DATA_W-1:0] pred_p0;
  logic              hit_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: prediction from history, wrap-around is intentional
  assign pred_p0 = h2_p1 + h3_p1;
  assign hit_p0  = (seq_i == pred_p0);

  always_comb begin
    state_d = state_p1;
    fill_d  = fill_p1;
    run_d   = run_p1;
    h1_d    = h1_p1;
    h2_d    = h2_p1;
    h3_d    = h3_p1;
    match_d = 1'b0;
    error_d = 1'b0;
    mcnt_d  = mcnt_p1;
    ecnt_d  = ecnt_p1;
    if (clear_i) begin
      state_d = FILL;
      fill_d  = '0;
      run_d   = '0;
      h1_d    = '0;
      h2_d    = '0;
      h3_d    = '0;
      mcnt_d  = '0;
      ecnt_d  = '0;
    end else if (valid_i) begin
      // History always advances so the checker resyncs after a bad sample
      h3_d = h2_p1;
      h2_d = h1_p1;
      h1_d = seq_i;
      unique case (state_p1)
        FILL: begin
          fill_d = fill_p1 + 2'd1;
          if (fill_p1 == 2'd2) state_d = CHECK;
        end
        CHECK: begin
          if (hit_p0) begin
            match_d = 1'b1;
            mcnt_d  = sat_inc(mcnt_p1);
            run_d   = run_p1 + RUN_W'(1);
            if (run_p1 + RUN_W'(1) >= LOCK_RUN) state_d = LOCK;
          end else begin
            error_d = 1'b1;
            ecnt_d  = sat_inc(ecnt_p1);
            run_d   = '0;
          end
        end
        LOCK: begin
          if (hit_p0) begin
            match_d = 1'b1;
            mcnt_d  = sat_inc(mcnt_p1);
          end else begin
            error_d = 1'b1;
            ecnt_d  = sat_inc(ecnt_p1);
            run_d   = '0;
            state_d = CHECK;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // Stage p1: registered state, history, pulses and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p1 <= FILL;
      fill_p1  <= '0;
      run_p1   <= '0;
      h1_p1    <= '0;
      h2_p1    <= '0;
      h3_p1    <= '0;
      match_p1 <= 1'b0;
      error_p1 <= 1'b0;
      mcnt_p1  <= '0;
      ecnt_p1  <= '0;
    end else begin
      state_p1 <= state_d;
      fill_p1  <= fill_d;
      run_p1   <= run_d;
      h1_p1    <= h1_d;
      h2_p1    <= h2_d;
      h3_p1    <= h3_d;
      match_p1 <= match_d;
      error_p1 <= error_d;
      mcnt_p1  <= mcnt_d;
      ecnt_p1  <= ecnt_d;
    end
  end

  assign match_o       = match_p1;
  assign error_o       = error_p1;
  assign locked_o      = (state_p1 == LOCK);
  assign match_count_o = mcnt_p1;
  assign err_count_o   = ecnt_p1;

endmodule

// File: tb/tb_seq_checker.sv
// Bench for seq_checker: directed scenarios plus a random stream, checked against a
// queue-based model; a second instance with 4-bit counters covers saturation.
module tb_seq_checker;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 16;
  localparam int CNT_W_S  = 4;
  localparam int LOCK_CNT = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic valid_i = 1'b0;
  logic clear_i = 1'b0;
  logic [DATA_W-1:0] seq_i = '0;

  logic a_match, a_error, a_locked;
  logic [CNT_W-1:0] a_mcnt, a_ecnt;
  logic b_match, b_error, b_locked;
  logic [CNT_W_S-1:0] b_mcnt, b_ecnt;

  seq_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut_a (
    .clk(clk), .reset_n(reset_n), .seq_i(seq_i), .valid_i(valid_i), .clear_i(clear_i),
    .match_o(a_match), .error_o(a_error), .locked_o(a_locked),
    .match_count_o(a_mcnt), .err_count_o(a_ecnt));

  seq_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W_S), .LOCK_CNT(LOCK_CNT)) dut_b (
    .clk(clk), .reset_n(reset_n), .seq_i(seq_i), .valid_i(valid_i), .clear_i(clear_i),
    .match_o(b_match), .error_o(b_error), .locked_o(b_locked),
    .match_count_o(b_mcnt), .err_count_o(b_ecnt));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: last three accepted samples, run of consecutive matches, totals
  logic [DATA_W-1:0] q[$];
  int     consec = 0;
  longint mtot = 0;
  longint etot = 0;
  bit     exp_m = 1'b0;
  bit     exp_e = 1'b0;

  // Independent generator for the random phases
  logic [DATA_W-1:0] g1, g2, g3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    q.delete();
    consec = 0;
    mtot = 0;
    etot = 0;
    exp_m = 1'b0;
    exp_e = 1'b0;
  endtask

  task automatic model_accept(input bit v, input logic [DATA_W-1:0] d, input bit c);
    logic [DATA_W-1:0] p;
    exp_m = 1'b0;
    exp_e = 1'b0;
    if (c) model_reset();
    else if (v) begin
      if (q.size() >= 3) begin
        p = q[q.size()-2] + q[q.size()-3];
        if (d == p) begin
          exp_m = 1'b1; mtot++; consec++;
        end else begin
          exp_e = 1'b1; etot++; consec = 0;
        end
      end
      q.push_back(d);
      if (q.size() > 3) void'(q.pop_front());
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".match"},  {63'd0, a_match},  {63'd0, exp_m});
    chk({ctx, ".error"},  {63'd0, a_error},  {63'd0, exp_e});
    chk({ctx, ".locked"}, {63'd0, a_locked}, {63'd0, (consec >= LOCK_CNT)});
    chk({ctx, ".mcnt"},   64'(a_mcnt), 64'(sat(mtot, CNT_W)));
    chk({ctx, ".ecnt"},   64'(a_ecnt), 64'(sat(etot, CNT_W)));
    chk({ctx, ".b_mcnt"}, 64'(b_mcnt), 64'(sat(mtot, CNT_W_S)));
    chk({ctx, ".b_ecnt"}, 64'(b_ecnt), 64'(sat(etot, CNT_W_S)));
  endtask

  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit c, input string ctx);
    valid_i = v;
    seq_i   = d;
    clear_i = c;
    @(posedge clk);
    #1;
    model_accept(v, d, c);
    check_all(ctx);
    valid_i = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic gen_seed();
    g3 = $urandom; g2 = $urandom; g1 = $urandom;
  endtask

  task automatic gen_next(output logic [DATA_W-1:0] n);
    n  = g2 + g3;
    g3 = g2;
    g2 = g1;
    g1 = n;
  endtask

  logic [DATA_W-1:0] s1[10] = '{0, 1, 1, 1, 2, 2, 3, 4, 5, 7};
  logic [DATA_W-1:0] s2[14] = '{0, 1, 1, 1, 2, 2, 3, 4, 5, 8, 9, 12, 16, 21};
  logic [DATA_W-1:0] sw[4]  = '{32'hFFFF_FFFF, 32'h2, 32'h1, 32'h1};
  logic [DATA_W-1:0] v;

  initial begin
    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #3 reset_n = 1'b1;

    // 1: clean stream locks after the 4th match
    foreach (s1[i]) step(1'b1, s1[i], 1'b0, "t1");
    chk("t1.final_mcnt", 64'(a_mcnt), 64'd7);
    chk("t1.final_lock", {63'd0, a_locked}, 64'd1);

    // 2: one bad value poisons the history for two more samples
    step(1'b0, '0, 1'b1, "t2.clr");
    foreach (s2[i]) step(1'b1, s2[i], 1'b0, "t2");
    chk("t2.final_ecnt", 64'(a_ecnt), 64'd3);

    // 3: same stream as 1 with random bubbles
    step(1'b0, '0, 1'b1, "t3.clr");
    foreach (s1[i]) begin
      repeat ($urandom_range(0, 2)) step(1'b0, $urandom, 1'b0, "t3.bub");
      step(1'b1, s1[i], 1'b0, "t3");
    end
    chk("t3.final_mcnt", 64'(a_mcnt), 64'd7);

    // 5a: async reset while locked, checked before any clock edge
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("t5.async");
    #1 reset_n = 1'b1;

    // 5b: clear together with valid drops the sample and restarts fill
    for (int i = 0; i < 5; i++) step(1'b1, s1[i], 1'b0, "t5.pre");
    step(1'b1, 32'd99, 1'b1, "t5.clrv");
    for (int i = 0; i < 4; i++) step(1'b1, s1[i], 1'b0, "t5.post");

    // 4: wrap-around of the prediction
    step(1'b0, '0, 1'b1, "t4.clr");
    foreach (sw[i]) step(1'b1, sw[i], 1'b0, "t4");
    chk("t4.wrap_match", {63'd0, a_match}, 64'd1);

    // 6: narrow counters saturate at 15
    step(1'b0, '0, 1'b1, "t6.clr");
    gen_seed();
    step(1'b1, g3, 1'b0, "t6.seed");
    step(1'b1, g2, 1'b0, "t6.seed");
    step(1'b1, g1, 1'b0, "t6.seed");
    for (int i = 0; i < 20; i++) begin
      gen_next(v);
      step(1'b1, v, 1'b0, "t6");
    end
    chk("t6.b_sat", 64'(b_mcnt), 64'd15);

    // Random stream: bubbles, corruption, occasional clear
    gen_seed();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) step(1'b1, $urandom, 1'b1, "rnd.clr");
      else if ($urandom_range(0, 9) < 3) step(1'b0, $urandom, 1'b0, "rnd.bub");
      else begin
        gen_next(v);
        if ($urandom_range(0, 15) == 0) v = v ^ (32'h1 << $urandom_range(0, 31));
        step(1'b1, v, 1'b0, "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
